down_counter_ctrl: RTL and testbench
====================================

// Module: down_counter_ctrl
// PURPOSE
// - Sequencing controller for the 4-bit down counter datapath: loads a start value, counts q down to 0,
//   supports pause/abort and flags expiry. It turns the free-running down counter into a
//   start/stop countdown timer for use by higher-level lab FSMs.
// - Sits between a requesting FSM (start/pause/abort) and the count register q that it owns.
// PARAMETERS
// - WIDTH  4  bit width of load_val and q; all arithmetic is modulo 2^WIDTH.
// PORTS
// - clk       in   1      rising-edge clock; the only clock.
// - reset     in   1      synchronous, active-high reset.
// - load_val  in   WIDTH  start count, sampled only on an accepted start.
// - start     in   1      level; accepted only in IDLE.
// - pause     in   1      level; holds q while high in RUN/PAUSE.
// - abort     in   1      level; returns to IDLE from any state.
// - q         out  WIDTH  current count (registered).
// - busy      out  1      1 in RUN or PAUSE (registered).
// - done      out  1      one-cycle expiry pulse (registered).
// - state     out  2      IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3.
// BEHAVIOUR
// - Reset (sync, checked first each edge): state=IDLE, q=0, busy=0, done=0, reload_reg=0.
// - Priority each edge: reset > abort > pause > start/decrement.
// - IDLE: abort -> stay IDLE, q<=0. Otherwise start=1 and load_val!=0 -> q<=load_val,
//   reload_reg<=load_val, RUN. start=1 and load_val==0 -> q<=0, DONE (immediate expiry).
//   start=0 -> hold.
// - RUN: abort -> IDLE, q<=0. Else pause -> PAUSE, q held. Else q==1 -> q<=0, DONE. Else q<=q-1.
// - PAUSE: abort -> IDLE, q<=0. Else pause=0 -> RUN (the decrement resumes on the following edge).
//   Else hold.
// - DONE: done=1 for exactly this one cycle, busy=0, q=0. Next edge -> IDLE unconditionally.
//   Start is ignored in DONE.
// - start is ignored in RUN/PAUSE: no restart or reload mid-count.
// - Latency: start accepted at edge E -> q=N after E. done is high in the cycle after edge E+N.
//   So done rises N edges after start is accepted.
// - Wrap-around: q never decrements below 0. The q==1 -> 0 step always exits RUN.
// - done is never asserted outside the DONE state, except via AUTO_RELOAD_EN (see below).
// - Reset asserted mid-count: the next edge forces the reset values. No done pulse is emitted.
// CONFIGURATION
// - Macro DOWN_COUNTER_CTRL_AUTO_RELOAD_EN.
// - Undefined: behaviour as above (one-shot).
// - Defined: in RUN with q==1 and no abort/pause -> q<=reload_reg, stay RUN, done=1 for one cycle.
//   - The count repeats every reload_reg cycles until abort or reset. DONE is entered only by
//     start with load_val==0.
//   - pause on the expiry cycle takes priority: go to PAUSE with q=1, no done pulse.
// TESTING
// - reset=1 for 2 edges, then 0 -> q=0, busy=0, done=0, state=0.
// - load_val=5, start 1 cycle -> q: 5,4,3,2,1,0. done=1 exactly 1 cycle when q=0, then state=IDLE.
// - load_val=6, start; pause high 3 cycles when q=3 -> q holds 3 for 3 cycles, state=2, busy=1,
//   then resumes 2,1,0 and done.
// - load_val=9, start; abort when q=4 -> next cycle q=0, state=IDLE, done never asserted.
// - load_val=0, start -> next cycle state=DONE, done=1, q=0. Start during RUN with load_val=2 is
//   ignored: the count is unchanged.
// - AUTO_RELOAD_EN, load_val=3, start -> q: 3,2,1,3,2,1,3... with done=1 on each 1->3 edge;
//   abort -> IDLE, q=0.

Source files
------------

// File: rtl/down_counter_ctrl.sv
// Start/pause/abort sequencer that owns a WIDTH-bit countdown register and flags expiry.
// Defining DOWN_COUNTER_CTRL_AUTO_RELOAD_EN makes RUN reload the start value on expiry instead of stopping.
module down_counter_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] reload_reg;
    logic             busy_reg;
    logic             done_reg;

    // busy and done are computed from the next state so they line up with state and q.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            q_reg      <= ZERO;
            reload_reg <= ZERO;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else if (abort) begin
            state_reg <= IDLE;
            q_reg     <= ZERO;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        if (load_val != ZERO) begin
                            state_reg  <= RUN;
                            q_reg      <= load_val;
                            reload_reg <= load_val;
                            busy_reg   <= 1'b1;
                        end else begin
                            state_reg <= DONE;
                            q_reg     <= ZERO;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end else begin
                        busy_reg <= 1'b0;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_reg <= PAUSE;
                        busy_reg  <= 1'b1;
                        done_reg  <= 1'b0;
                    end else if (q_reg <= ONE) begin
                        // q==0 cannot occur in RUN; treating it like q==1 keeps the count from wrapping.
`ifdef DOWN_COUNTER_CTRL_AUTO_RELOAD_EN
                        state_reg <= RUN;
                        q_reg     <= reload_reg;
                        busy_reg  <= 1'b1;
                        done_reg  <= 1'b1;
`else
                        state_reg <= DONE;
                        q_reg     <= ZERO;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
`endif
                    end else begin
                        q_reg    <= q_reg - ONE;
                        busy_reg <= 1'b1;
                        done_reg <= 1'b0;
                    end
                end
                PAUSE: begin
                    done_reg <= 1'b0;
                    busy_reg <= 1'b1;
                    if (!pause) begin
                        state_reg <= RUN;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    q_reg     <= ZERO;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    q_reg     <= ZERO;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign q     = q_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;
    assign state = state_reg;

endmodule

// File: tb/tb_down_counter_ctrl.sv
// Directed-vector bench for down_counter_ctrl: inputs are driven on the falling edge, outputs checked 1ns after the rising edge.
module tb_down_counter_ctrl;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             pause;
    logic             abort;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    int checks = 0;
    int fails  = 0;

    down_counter_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .load_val (load_val),
        .start    (start),
        .pause    (pause),
        .abort    (abort),
        .q        (q),
        .busy     (busy),
        .done     (done),
        .state    (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             rst;
        logic             st;
        logic             pa;
        logic             ab;
        logic [WIDTH-1:0] lv;
        logic [WIDTH-1:0] eq;
        logic             eb;
        logic             ed;
        logic [1:0]       es;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic st, input logic pa, input logic ab,
                       input int lv, input int eq, input logic eb, input logic ed, input int es);
        vec_t v;
        v.rst = rst; v.st = st; v.pa = pa; v.ab = ab;
        v.lv = WIDTH'(lv); v.eq = WIDTH'(eq); v.eb = eb; v.ed = ed; v.es = 2'(es);
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s vec %0d: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic st, input logic pa, input logic ab, input int lv);
        @(negedge clk);
        reset = rst; start = st; pause = pa; abort = ab; load_val = WIDTH'(lv);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0; load_val = '0;

        // rst st pa ab lv | q busy done state
        add(1,0,0,0,0,  0,0,0,0);
        add(1,0,0,0,0,  0,0,0,0);
        add(0,0,0,0,0,  0,0,0,0);
`ifndef DOWN_COUNTER_CTRL_AUTO_RELOAD_EN
        // load 5: 5,4,3,2,1,0 with done on the 0 cycle
        add(0,1,0,0,5,  5,1,0,1);
        add(0,0,0,0,0,  4,1,0,1);
        add(0,0,0,0,0,  3,1,0,1);
        add(0,0,0,0,0,  2,1,0,1);
        add(0,0,0,0,0,  1,1,0,1);
        add(0,0,0,0,0,  0,0,1,3);
        add(0,0,0,0,0,  0,0,0,0);
        // load 6, pause three cycles at q=3
        add(0,1,0,0,6,  6,1,0,1);
        add(0,0,0,0,0,  5,1,0,1);
        add(0,0,0,0,0,  4,1,0,1);
        add(0,0,0,0,0,  3,1,0,1);
        add(0,0,1,0,0,  3,1,0,2);
        add(0,0,1,0,0,  3,1,0,2);
        add(0,0,1,0,0,  3,1,0,2);
        add(0,0,0,0,0,  3,1,0,1);
        add(0,0,0,0,0,  2,1,0,1);
        add(0,0,0,0,0,  1,1,0,1);
        add(0,0,0,0,0,  0,0,1,3);
        add(0,0,0,0,0,  0,0,0,0);
        // load 9, abort at q=4
        add(0,1,0,0,9,  9,1,0,1);
        add(0,0,0,0,0,  8,1,0,1);
        add(0,0,0,0,0,  7,1,0,1);
        add(0,0,0,0,0,  6,1,0,1);
        add(0,0,0,0,0,  5,1,0,1);
        add(0,0,0,0,0,  4,1,0,1);
        add(0,0,0,1,0,  0,0,0,0);
        add(0,0,0,0,0,  0,0,0,0);
        // load 0 expires immediately; start held into DONE is ignored
        add(0,1,0,0,0,  0,0,1,3);
        add(0,1,0,0,0,  0,0,0,0);
        // start during RUN ignored
        add(0,1,0,0,3,  3,1,0,1);
        add(0,1,0,0,7,  2,1,0,1);
        add(0,1,0,0,2,  1,1,0,1);
        add(0,1,0,0,2,  0,0,1,3);
        add(0,1,0,0,5,  0,0,0,0);
        add(0,0,0,0,0,  0,0,0,0);
        // abort beats start; reset mid-count gives no done
        add(0,1,0,1,4,  0,0,0,0);
        add(0,1,0,0,5,  5,1,0,1);
        add(0,0,0,0,0,  4,1,0,1);
        add(1,0,0,0,0,  0,0,0,0);
        add(0,0,0,0,0,  0,0,0,0);
        // abort from PAUSE; pause beats decrement at q=1
        add(0,1,0,0,2,  2,1,0,1);
        add(0,0,1,0,0,  2,1,0,2);
        add(0,0,1,1,0,  0,0,0,0);
        add(0,1,0,0,2,  2,1,0,1);
        add(0,0,0,0,0,  1,1,0,1);
        add(0,0,1,0,0,  1,1,0,2);
        add(0,0,0,0,0,  1,1,0,1);
        add(0,0,0,0,0,  0,0,1,3);
        add(0,0,0,0,0,  0,0,0,0);
`else
        // auto reload: 3,2,1,3,2,1,3 with done on each reload, then abort
        add(0,1,0,0,3,  3,1,0,1);
        add(0,0,0,0,0,  2,1,0,1);
        add(0,0,0,0,0,  1,1,0,1);
        add(0,0,0,0,0,  3,1,1,1);
        add(0,0,0,0,0,  2,1,0,1);
        add(0,0,0,0,0,  1,1,0,1);
        add(0,0,1,0,0,  1,1,0,2);
        add(0,0,0,0,0,  1,1,0,1);
        add(0,0,0,0,0,  3,1,1,1);
        add(0,0,0,1,0,  0,0,0,0);
        add(0,1,0,0,0,  0,0,1,3);
        add(0,0,0,0,0,  0,0,0,0);
`endif

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].st, vecs[i].pa, vecs[i].ab, int'(vecs[i].lv));
            check("q",     i, int'(q),     int'(vecs[i].eq));
            check("busy",  i, int'(busy),  int'(vecs[i].eb));
            check("done",  i, int'(done),  int'(vecs[i].ed));
            check("state", i, int'(state), int'(vecs[i].es));
            $display("vec %0d: rst=%0b start=%0b pause=%0b abort=%0b load=%0d -> q=%0d busy=%0b done=%0b state=%0d",
                     i, vecs[i].rst, vecs[i].st, vecs[i].pa, vecs[i].ab, vecs[i].lv, q, busy, done, state);
        end

`ifndef DOWN_COUNTER_CTRL_AUTO_RELOAD_EN
        // done latency: for N=1..15, done must rise exactly N edges after the accepting edge
        for (int n = 1; n < 16; n++) begin
            int edges;
            int pulses;
            edges  = 0;
            pulses = 0;
            drive(0, 1, 0, 0, n);
            drive(0, 0, 0, 0, 0);
            edges = 1;
            while (!done && edges < 40) begin
                drive(0, 0, 0, 0, 0);
                edges++;
            end
            check("done_latency", n, edges, n);
            if (done) pulses++;
            drive(0, 0, 0, 0, 0);
            if (done) pulses++;
            check("done_width", n, pulses, 1);
            check("idle_after_done", n, int'(state), 0);
            $display("latency n=%0d: done after %0d edges, pulse cycles=%0d", n, edges, pulses);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
